// File: rtl/insn_encoder.sv
// insn_encoder: packs decoded RV64 fields into 32-bit words, expands li, tags each word with its pc.
// Optional immediate range checking is enabled with `define INSN_ENC_RANGE_CHECK_EN.
module insn_encoder #(
  parameter logic [63:0] START_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [63:0] out_pc,
  output logic        out_err
);
  typedef enum logic {RUN, LI2} state_t;
  state_t state;
  logic [11:0] lo, li_lo;
  logic [19:0] hi;
  logic [4:0] li_rd;
  logic [31:0] enc;
  logic two, err, li_err, fire_in, fire_out;
  assign lo = imm[11:0];
  // Rounding by 0x800 before the shift is the same as adding bit 11 into the upper field.
  assign hi = imm[31:12] + {19'd0, imm[11]};
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign fire_in = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;
  always_comb begin
    enc = '0;
    two = 1'b0;
    case (fmt)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc = {imm[31:12], rd, opcode};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      3'd6: begin
        enc = (hi == 20'd0) ? {lo, 5'd0, 3'd0, rd, 7'b0010011} : {hi, rd, 7'b0110111};
        two = (hi != 20'd0) && (lo != 12'd0);
      end
      default: enc = '0;
    endcase
  end
`ifdef INSN_ENC_RANGE_CHECK_EN
  function automatic logic fits(input logic [63:0] v, input int n);
    logic [63:0] s;
    s = v << (64 - n);
    return v == $unsigned($signed(s) >>> (64 - n));
  endfunction
  always_comb begin
    case (fmt)
      3'd1, 3'd2: err = !fits(imm, 12);
      3'd3: err = !fits(imm, 13) || imm[0];
      3'd4: err = !fits(imm, 32) || (imm[11:0] != 12'd0);
      3'd5: err = !fits(imm, 21) || imm[0];
      3'd6: err = !fits(imm, 32);
      3'd7: err = 1'b1;
      default: err = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[63:32];
  assign err = (fmt == 3'd7);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      out_valid <= 1'b0;
      out_insn <= '0;
      out_err <= 1'b0;
      out_pc <= START_PC;
      li_rd <= '0;
      li_lo <= '0;
      li_err <= 1'b0;
    end else begin
      if (fire_out) out_pc <= out_pc + 64'd4;
      if (state == LI2) begin
        if (fire_out) begin
          out_insn <= {li_lo, li_rd, 3'd0, li_rd, 7'b0011011};
          out_err <= li_err;
          state <= RUN;
        end
      end else if (fire_in) begin
        out_valid <= 1'b1;
        out_insn <= enc;
        out_err <= err;
        if (two) begin
          li_rd <= rd;
          li_lo <= lo;
          li_err <= err;
          state <= LI2;
        end
      end else if (fire_out) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed vectors with a scoreboard queue popped by an output monitor.
module tb_insn_encoder;
  localparam logic [63:0] START_PC = 64'hFFFF_FFFF_FFFF_FFF8;
`ifdef INSN_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif
  logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [63:0] imm, out_pc, exp_pc, hold_pc;
  logic [31:0] out_insn;
  typedef struct packed {logic [31:0] insn; logic [63:0] pc; logic err;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  insn_encoder #(.START_PC(START_PC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h at pc %h expected none", out_insn, out_pc);
      end else begin
        e = sb.pop_front();
        check("insn", 64'(out_insn), 64'(e.insn));
        check("pc", out_pc, e.pc);
        check("err", 64'(out_err), 64'(e.err));
      end
    end
  end

  task automatic push(input logic [31:0] insn, input logic err);
    sb.push_back('{insn, exp_pc, err});
    exp_pc += 64'd4;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] im);
    int k = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1 check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    exp_pc = START_PC;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_insn", 64'(out_insn), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_pc", out_pc, START_PC);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, -64'sd1);       push(32'hFFF30293, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);         push(32'h00208463, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd9);         push(32'h00208463, RC);
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 64'd2048);      push(32'h80030293, RC);
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 64'd0);        push(32'h403100B3, 1'b0);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, -64'sd8);       push(32'hFE513C23, 1'b0);
    send(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);  push(32'h123453B7, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);      push(32'h001000EF, 1'b0);
    send(3'd6, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);         push(32'h00500193, 1'b0);
    send(3'd6, 7'h00, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1);       push(32'hFFF00213, 1'b0);
    send(3'd6, 7'h00, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);  push(32'h12345337, 1'b0);
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345FFF);
    push(32'h12346537, 1'b0);
    push(32'hFFF5051B, 1'b0);
    @(negedge clk);
    check("li2_ready", 64'(in_ready), 64'd0);
    send(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);         push(32'h00000000, 1'b1);
    send(3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1_0000_0000); push(32'h00000093, RC);
    drain();
    out_ready = 1'b0;
    send(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
    hold_pc = exp_pc;
    push(32'h123453B7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_insn", 64'(out_insn), 64'h123453B7);
      check("bp_pc", out_pc, hold_pc);
      check("bp_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'd1);
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 64'd0);        push(32'h403100B3, 1'b0);
    drain();
    out_ready = 1'b0;
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345FFF);
    @(negedge clk);
    check("li2_lui_visible", 64'(out_insn), 64'h12346537);
    check("li2_blocked", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    exp_pc = START_PC;
    @(negedge clk);
    check("li2_rst_valid", 64'(out_valid), 64'd0);
    check("li2_rst_pc", out_pc, START_PC);
    check("li2_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, -64'sd1);       push(32'hFFF30293, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/insn_encoder.md
# insn_encoder

Pipelined RV64 instruction encoder. It accepts decoded fields (opcode, registers, funct3/funct7, 64-bit immediate, format select) and packs them into 32-bit instruction words, scattering the immediate into the per-format bit positions of the ISA. It expands the `li` pseudo-op into LUI/ADDIW/ADDI sequences. It sits on the program-load / self-test path, feeding instruction memory upstream of fetch, and tags each word with its target address.

## Interface

Parameters:
- `START_PC`, default 64'h0, address tagged on the first emitted word after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder accepts bundle this cycle.
- `fmt` input 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI pseudo-op, 7=illegal.
- `opcode` input 7: opcode[6:0]; ignored for LI.
- `rd`, `rs1`, `rs2` input 5 each: register indices.
- `funct3` input 3, `funct7` input 7: function fields.
- `imm` input 64: immediate, two's complement.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: consumer accepts word.
- `out_insn` output 32: encoded instruction.
- `out_pc` output 64: address of `out_insn`.
- `out_err` output 1: immediate out of range for `fmt`, or illegal `fmt`.

## Operation

- In accept fire (`in_valid & in_ready`), the encoder registers the encoded word into the output stage.
- Immediate packing:
  - I: insn[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Register and function fields:
  - R: funct7/rs2/rs1/funct3/rd in standard positions.
  - I, S, B: fill their register fields and funct3.
  - U, J: fill rd only.
- LI:
  - lo = imm[11:0] (signed); hi = (imm[31:0] + 0x800) >> 12, truncated to 20 bits.
  - hi==0: one word, ADDI rd,x0,lo (0010011, funct3 0).
  - lo==0 and hi!=0: one word, LUI rd,hi (0110111).
  - Otherwise two words: LUI rd,hi, then ADDIW rd,rd,lo (0011011, funct3 0).
- fmt=7: out_insn=0, out_err=1.
- FSM has two states:
  - RUN: `in_ready = !out_valid | out_ready`. An accept that needs two words loads the LUI word, latches rd/lo, and moves to LI2.
  - LI2: `in_ready=0`. On output fire, loads the ADDIW word and returns to RUN.
- `out_pc` starts at START_PC and increments by 4 on every output fire (`out_valid & out_ready`). It wraps modulo 2^64.

## Timing

- Reset values: out_valid=0, out_insn=0, out_err=0, out_pc=START_PC, state=RUN, in_ready=1.
- Latency: word visible on `out_valid` 1 cycle after accept. The ADDIW word is visible the cycle after the LUI fire.
- Throughput: 1 word/cycle under `out_ready=1`. A two-word LI blocks input for one extra cycle.
- Backpressure: while `out_valid & !out_ready`, out_insn, out_pc and out_err hold stable and `in_ready=0`.
- Simultaneous output fire and input accept in RUN: the new word replaces the old one in the same edge, with no bubble.
- Reset asserted in LI2: the pending ADDIW is discarded, state returns to RUN, and out_pc returns to START_PC.

## Configuration

- `INSN_ENC_RANGE_CHECK_EN` defined: out_err=1 in each of these cases:
  - I/S immediate is not the sign-extension of imm[11:0].
  - B immediate is not the sign-extension of imm[12:0], or imm[0]=1.
  - J immediate is not the sign-extension of imm[20:0], or imm[0]=1.
  - U immediate is not the sign-extension of imm[31:0], or imm[11:0]!=0.
  - LI immediate is not the sign-extension of imm[31:0].
  - fmt=7.
- Flagged words are still emitted, with truncated fields.
- Undefined: out_err=1 only for fmt=7. Immediates are silently truncated and the range-check logic is not synthesized.

## Test plan

- I-type: fmt=1, opcode=0x13, rd=5, rs1=6, funct3=0, imm=-1 -> out_insn=0xFFF30293, out_err=0, out_pc=START_PC, one cycle after accept.
- B-type: fmt=3, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> out_insn=0x00208463. With imm=9 and macro defined -> out_err=1.
- LI two-word: fmt=6, rd=10, imm=0x12345FFF, START_PC=0 -> 0x12346537 @pc 0, then 0xFFF5051B @pc 4. in_ready=0 between the two words.
- Range: fmt=1, imm=2048 -> with macro, out_err=1 and insn[31:20]=0x800; without macro, out_err=0 and the same insn.
- Backpressure: hold out_ready=0 for 3 cycles with a word pending -> out_insn/out_pc stable, in_ready=0. Release -> next bundle accepted in the same cycle.
- Reset in LI2: reset asserted the cycle after LUI is visible -> out_valid=0, out_pc=START_PC next cycle, ADDIW never emitted.
